// File: rtl/prga_enc_if.sv
// Start handshake plus the single-port S, pt and ct RAM ports used by prga_enc.
interface prga_enc_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic [7:0] ct_addr;
  logic [7:0] ct_wrdata;
  logic       ct_wren;

  // Engine side: drives addresses, write data, enables and rdy.
  modport slave (
    input  en, s_rddata, pt_rddata,
    output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );

  // Environment side: issues en and returns RAM read data.
  modport master (
    output en, s_rddata, pt_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );
endinterface

// File: rtl/prga_enc.sv
// ARC4 keystream encryptor: reads a length-prefixed pt buffer, XORs it with the
// PRGA keystream drawn from a pre-scheduled S RAM and writes a length-prefixed ct buffer.
module prga_enc (
  input  logic       clk,
  input  logic       rst_n,
  prga_enc_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, LEN_A, LEN_D, WR_LEN,
    SI_A, SI_D, SJ_A, SJ_D,
    WR_I, WR_J, PAD_A, PAD_D, WR_CT
  } state_t;

  state_t     state, state_nx;
  logic [7:0] i, j, k, len;
  logic [7:0] si, sj, pad, pt_byte;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and Moore output decode; outputs are pure functions of state so
  // an asynchronous reset drops every enable and address immediately.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_nx      = state;
    bus.rdy       = 1'b0;
    bus.s_addr    = 8'd0;
    bus.s_wrdata  = 8'd0;
    bus.s_wren    = 1'b0;
    bus.pt_addr   = 8'd0;
    bus.ct_addr   = 8'd0;
    bus.ct_wrdata = 8'd0;
    bus.ct_wren   = 1'b0;
    unique case (state)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) state_nx = LEN_A;
      end
      LEN_A: begin
        bus.pt_addr = 8'd0;
        state_nx    = LEN_D;
      end
      LEN_D: state_nx = WR_LEN;
      WR_LEN: begin
        bus.ct_addr   = 8'd0;
        bus.ct_wrdata = len;
        bus.ct_wren   = 1'b1;
        state_nx      = (len == 8'd0) ? IDLE : SI_A;
      end
      SI_A: begin
        bus.s_addr = i + 8'd1;
        state_nx   = SI_D;
      end
      SI_D: state_nx = SJ_A;
      SJ_A: begin
        bus.s_addr = j + si;
        state_nx   = SJ_D;
      end
      SJ_D: state_nx = WR_I;
      WR_I: begin
        bus.s_addr   = i;
        bus.s_wrdata = sj;
        bus.s_wren   = 1'b1;
        state_nx     = WR_J;
      end
      WR_J: begin
        bus.s_addr   = j;
        bus.s_wrdata = si;
        bus.s_wren   = 1'b1;
        state_nx     = PAD_A;
      end
      PAD_A: begin
        // Pre-swap si+sj equals post-swap S[i]+S[j], so no re-read is needed.
        bus.s_addr  = si + sj;
        bus.pt_addr = k;
        state_nx    = PAD_D;
      end
      PAD_D: state_nx = WR_CT;
      WR_CT: begin
        bus.ct_addr   = k;
        bus.ct_wrdata = pad ^ pt_byte;
        bus.ct_wren   = 1'b1;
        state_nx      = (k == len) ? IDLE : SI_A;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: indices, captured RAM bytes and the buffer length.
  // k advances together with i at the start of each byte, so it already holds
  // the 1-based byte index by PAD_A/WR_CT and never passes 255.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain flops, not RAM storage, so they take the async reset too.
    if (!rst_n) begin
      i       <= 8'd0;
      j       <= 8'd0;
      k       <= 8'd0;
      len     <= 8'd0;
      si      <= 8'd0;
      sj      <= 8'd0;
      pad     <= 8'd0;
      pt_byte <= 8'd0;
    end else begin
      case (state)
        IDLE: if (bus.en) begin
          i <= 8'd0;
          j <= 8'd0;
          k <= 8'd0;
        end
        LEN_D: len <= bus.pt_rddata;
        SI_A: begin
          i <= i + 8'd1;
          k <= k + 8'd1;
        end
        SI_D: si <= bus.s_rddata;
        SJ_A: j  <= j + si;
        SJ_D: sj <= bus.s_rddata;
        PAD_D: begin
          pad     <= bus.s_rddata;
          pt_byte <= bus.pt_rddata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prga_enc.sv
// Bench for prga_enc: behavioural RAMs, a textbook ARC4 reference model and a
// write monitor that checks every RAM write the engine issues.
module tb_prga_enc;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  prga_enc_if bus ();

  prga_enc dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural RAMs with synchronous read plus a loader port for the bench.
  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic       ld_en;
  logic [7:0] ld_addr, ld_s, ld_pt;

  always @(posedge clk) begin
    if (bus.s_wren)  s_mem[bus.s_addr] <= bus.s_wrdata;
    else if (ld_en)  s_mem[ld_addr]    <= ld_s;
    if (ld_en)       pt_mem[ld_addr]   <= ld_pt;
    if (bus.ct_wren) ct_mem[bus.ct_addr] <= bus.ct_wrdata;
    else if (ld_en)  ct_mem[ld_addr]     <= 8'hEE;
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.pt_rddata <= pt_mem[bus.pt_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  int n_s_wr = 0;
  int n_ct_wr = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: S image, pt image, expected ct image and expected writes.
  logic [7:0] m_s  [256];
  logic [7:0] m_pt [256];
  logic [7:0] m_ct [256];
  wr_t exp_s[$];
  wr_t exp_ct[$];

  // Textbook ARC4 PRGA over m_pt[1..L], updating m_s in place.
  task automatic model_run(input bit push);
    logic [7:0] len, i, j, si, sj, t;
    len = m_pt[0];
    m_ct[0] = len;
    if (push) exp_ct.push_back('{addr: 8'd0, data: len});
    i = 8'd0;
    j = 8'd0;
    for (int k = 1; k <= int'(len); k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      si = m_s[i];
      sj = m_s[j];
      m_s[i] = sj;
      m_s[j] = si;
      t = m_s[i] + m_s[j];
      m_ct[k] = m_pt[k] ^ m_s[t];
      if (push) begin
        exp_s.push_back('{addr: i, data: sj});
        exp_s.push_back('{addr: j, data: si});
        exp_ct.push_back('{addr: 8'(k), data: m_ct[k]});
      end
    end
  endtask

  // Write monitor: every engine write must match the next expected write.
  always @(negedge clk) begin
    wr_t w;
    if (rst_n) begin
      if (bus.s_wren) begin
        n_s_wr++;
        check("s_write_expected", int'(exp_s.size() != 0), 1);
        if (exp_s.size() != 0) begin
          w = exp_s.pop_front();
          check("s_wr_addr", int'(bus.s_addr), int'(w.addr));
          check("s_wr_data", int'(bus.s_wrdata), int'(w.data));
        end
      end
      if (bus.ct_wren) begin
        n_ct_wr++;
        check("ct_write_expected", int'(exp_ct.size() != 0), 1);
        if (exp_ct.size() != 0) begin
          w = exp_ct.pop_front();
          check("ct_wr_addr", int'(bus.ct_addr), int'(w.addr));
          check("ct_wr_data", int'(bus.ct_wrdata), int'(w.data));
        end
      end
    end
  end

  // Copy the model images into the RAMs; ct is filled with a marker byte.
  task automatic load_mems();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 8'(a);
      ld_s    = m_s[a];
      ld_pt   = m_pt[a];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic rand_images(input int len);
    for (int a = 0; a < 256; a++) begin
      m_s[a]  = 8'($urandom);
      m_pt[a] = 8'($urandom);
    end
    m_pt[0] = 8'(len);
  endtask

  // Count cycles from the accept edge until rdy is seen high, bounded.
  task automatic wait_rdy(input int busy_at, output int cnt);
    cnt = 0;
    while (cnt < 3000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (busy_at >= 0 && cnt == busy_at)     bus.en = 1'b1;
      if (busy_at >= 0 && cnt == busy_at + 1) bus.en = 1'b0;
      if (bus.rdy) break;
    end
  endtask

  task automatic run_enc(input int busy_at, output int lat);
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    check("rdy_low_after_accept", int'(bus.rdy), 0);
    wait_rdy(busy_at, lat);
  endtask

  task automatic verify_mems();
    for (int a = 0; a <= int'(m_pt[0]); a++)
      check($sformatf("ct[%0d]", a), int'(ct_mem[a]), int'(m_ct[a]));
    for (int a = 0; a < 256; a++)
      check($sformatf("s[%0d]", a), int'(s_mem[a]), int'(m_s[a]));
    check("exp_s_left", exp_s.size(), 0);
    check("exp_ct_left", exp_ct.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"},       int'(bus.rdy), 1);
    check({tag, "_s_addr"},    int'(bus.s_addr), 0);
    check({tag, "_s_wrdata"},  int'(bus.s_wrdata), 0);
    check({tag, "_s_wren"},    int'(bus.s_wren), 0);
    check({tag, "_pt_addr"},   int'(bus.pt_addr), 0);
    check({tag, "_ct_addr"},   int'(bus.ct_addr), 0);
    check({tag, "_ct_wrdata"}, int'(bus.ct_wrdata), 0);
    check({tag, "_ct_wren"},   int'(bus.ct_wren), 0);
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nw;
    int lens[4];
    logic [7:0] s_saved [256];
    logic [7:0] pt_saved [256];
    logic [7:0] key [3];

    bus.en = 1'b0;
    ld_en = 1'b0;
    ld_addr = 8'd0;
    ld_s = 8'd0;
    ld_pt = 8'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Known vector with identity S.
    for (int a = 0; a < 256; a++) begin
      m_s[a] = 8'(a);
      m_pt[a] = 8'd0;
    end
    m_pt[0] = 8'h03; m_pt[1] = 8'h41; m_pt[2] = 8'h42; m_pt[3] = 8'h43;
    load_mems();
    model_run(1'b1);
    run_enc(-1, lat);
    check("known_lat", lat, 30);
    check("known_ct0", int'(ct_mem[0]), 'h03);
    check("known_ct1", int'(ct_mem[1]), 'h43);
    check("known_ct2", int'(ct_mem[2]), 'h47);
    check("known_ct3", int'(ct_mem[3]), 'h44);
    check("known_s2", int'(s_mem[2]), 'h03);
    check("known_s3", int'(s_mem[3]), 'h05);
    check("known_s5", int'(s_mem[5]), 'h02);
    verify_mems();

    // Zero length: only ct[0] is written, S untouched.
    for (int a = 0; a < 256; a++) m_s[a] = 8'(a);
    m_pt[0] = 8'd0;
    load_mems();
    model_run(1'b1);
    n_s_wr = 0;
    run_enc(-1, lat);
    check("zero_lat", lat, 3);
    check("zero_ct0", int'(ct_mem[0]), 0);
    check("zero_s_writes", n_s_wr, 0);
    verify_mems();

    // Random runs, one with a stray en pulse while busy.
    lens = '{1, 2, 37, 200};
    foreach (lens[n]) begin
      rand_images(lens[n]);
      load_mems();
      model_run(1'b1);
      n_ct_wr = 0;
      run_enc((lens[n] == 37) ? 5 : -1, lat);
      check($sformatf("rand%0d_lat", lens[n]), lat, 3 + 9 * lens[n]);
      check($sformatf("rand%0d_ct_writes", lens[n]), n_ct_wr, lens[n] + 1);
      verify_mems();
    end

    // Asynchronous reset during WR_J, then a full rerun from restored S.
    rand_images(6);
    s_saved = m_s;
    load_mems();
    model_run(1'b1);
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    nw = 0;
    for (int c = 0; c < 200 && nw < 2; c++) begin
      @(posedge clk);
      #1;
      if (bus.s_wren) nw++;
    end
    check("reached_wr_j", nw, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_s.delete();
    exp_ct.delete();
    @(negedge clk);
    rst_n = 1'b1;
    m_s = s_saved;
    load_mems();
    model_run(1'b1);
    run_enc(-1, lat);
    check("after_reset_lat", lat, 3 + 9 * 6);
    verify_mems();

    // Back-to-back with en held: second run reuses the S left by the first.
    rand_images(4);
    load_mems();
    model_run(1'b1);
    model_run(1'b1);
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_rdy_low", int'(bus.rdy), 0);
    wait_rdy(-1, lat);
    check("b2b_lat1", lat, 39);
    @(posedge clk);
    #1;
    check("b2b_restart", int'(bus.rdy), 0);
    bus.en = 1'b0;
    wait_rdy(-1, lat);
    check("b2b_lat2", lat, 39);
    verify_mems();

    // Round trip: KSA with key 00 00 18, encrypt 255 bytes, decrypt with the model.
    key = '{8'h00, 8'h00, 8'h18};
    for (int a = 0; a < 256; a++) m_s[a] = 8'(a);
    begin
      logic [7:0] jj, tmp;
      jj = 8'd0;
      for (int a = 0; a < 256; a++) begin
        jj = jj + m_s[a] + key[a % 3];
        tmp = m_s[a];
        m_s[a] = m_s[jj];
        m_s[jj] = tmp;
      end
    end
    s_saved = m_s;
    for (int a = 1; a < 256; a++) m_pt[a] = 8'($urandom);
    m_pt[0] = 8'd255;
    pt_saved = m_pt;
    load_mems();
    model_run(1'b1);
    run_enc(-1, lat);
    check("l255_lat", lat, 2298);
    verify_mems();
    m_s = s_saved;
    for (int a = 0; a < 256; a++) m_pt[a] = ct_mem[a];
    model_run(1'b0);
    for (int a = 1; a < 256; a++)
      check($sformatf("roundtrip[%0d]", a), int'(m_ct[a]), int'(pt_saved[a]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
